instruction_queue: RTL and testbench

In-order instruction queue in front of the reservation station. Front-end logic pushes 16-bit instructions into a circular buffer. The queue issues them one at a time through the reservation station's `instruction`/`Adderin` inputs, and only while the station reports a free entry on `disponivel`. It guarantees the station never samples an issue while its `Busy` state is stale.

---
 rtl/instruction_queue.sv | 117 +++++++++++
 tb/tb_instruction_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
//
// In-order circular instruction queue that feeds a reservation station.
// Front-end logic pushes 16-bit instructions. They are issued one at a time,
// verbatim and in FIFO order, but only while the station reports a free entry.
// At least one idle cycle always follows an issue. This gives the station one
// edge to update its Busy state before `disponivel` is trusted again.
//
// Optional feature (compile-time macro INSTRUCTION_QUEUE_BYPASS_EN):
//   When the macro is defined, a push into an empty queue that could issue
//   immediately goes straight to issueInst/issueEnable at the push edge.
//   When the macro is not defined, every instruction passes through storage.
//
// Parameters
//   DEPTH       number of entries (power of two)
//   ADDR_W      log2(DEPTH), pointer width
//
// Ports
//   Clock        in   sole clock, posedge
//   Reset        in   synchronous, active-high
//   inValid      in   upstream offers inInst
//   inInst       in   [15:0] instruction ([3:0] op, [6:4] Rx, [9:7] Ry, [12:10] Rz)
//   inReady      out  push accepted this cycle (~full & ~Reset)
//   flush        in   synchronous discard of all queued instructions
//   disponivel   in   station has at least one free entry
//   issueEnable  out  registered issue strobe (station Adderin)
//   issueInst    out  [15:0] registered issued instruction (station instruction)
//   count        out  [ADDR_W:0] registered occupancy, 0..DEPTH
//   empty        out  count == 0
//   full         out  count == DEPTH
// -----------------------------------------------------------------------------
module instruction_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              inValid,
  input  logic [15:0]       inInst,
  output logic              inReady,
  input  logic              flush,
  input  logic              disponivel,
  output logic              issueEnable,
  output logic [15:0]       issueInst,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;

  logic push;
  logic allow;
  logic bypass;
  logic store;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // Deliberately does not look ahead to a same-edge pop when full.
  assign inReady = ~full & ~Reset;
  assign push    = inValid & inReady;

  // ~issueEnable forces an idle cycle after each issue, so the station has
  // had an edge to set Busy before disponivel is used again.
  assign allow   = ~empty & disponivel & ~issueEnable;

`ifdef INSTRUCTION_QUEUE_BYPASS_EN
  assign bypass  = empty & push & disponivel & ~issueEnable;
`else
  assign bypass  = 1'b0;
`endif

  // A bypassed instruction never touches storage or the pointers.
  assign store   = push & ~bypass;

  // Storage: not reset, and untouched by flush.
  always_ff @(posedge Clock) begin
    if (!Reset && !flush && store) begin
      mem[wp] <= inInst;
    end
  end

  // Pointers, occupancy and issue register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      issueEnable <= 1'b0;
      issueInst   <= 16'h0000;
    end else if (flush) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      issueEnable <= 1'b0;
    end else begin
      issueEnable <= allow | bypass;
      if (allow) begin
        issueInst <= mem[rp];
        rp        <= rp + ADDR_W'(1);
      end else if (bypass) begin
        issueInst <= inInst;
      end
      if (store) begin
        wp <= wp + ADDR_W'(1);
      end
      // A simultaneous store and issue leaves count unchanged.
      count <= count + {{ADDR_W{1'b0}}, store} - {{ADDR_W{1'b0}}, allow};
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
module tb_instruction_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              inValid = 1'b0;
  logic [15:0]       inInst = 16'h0000;
  logic              inReady;
  logic              flush = 1'b0;
  logic              disponivel = 1'b0;
  logic              issueEnable;
  logic [15:0]       issueInst;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;

  instruction_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset), .inValid(inValid), .inInst(inInst),
    .inReady(inReady), .flush(flush), .disponivel(disponivel),
    .issueEnable(issueEnable), .issueInst(issueInst), .count(count),
    .empty(empty), .full(full)
  );

  always #5 Clock = ~Clock;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: the queue contents as a plain list; sb holds the
  // instructions expected to appear on the issue port, oldest first.
  logic [15:0] pend[$];
  logic [15:0] sb[$];
  logic        expEn   = 1'b0;
  logic [15:0] expInst = 16'h0000;
  bit          started = 0;

  always @(posedge Clock) begin
    int  sz;
    bit  acc;
    bit  iss;
    sz = pend.size();
    started = 1;
    if (Reset) begin
      pend.delete();
      expEn   = 1'b0;
      expInst = 16'h0000;
    end else if (flush) begin
      pend.delete();
      expEn = 1'b0;
    end else begin
      acc = inValid && (sz < DEPTH);
      iss = (sz > 0) && disponivel && !expEn;
`ifdef INSTRUCTION_QUEUE_BYPASS_EN
      if (sz == 0 && acc && disponivel && !expEn) iss = 1;
`endif
      if (acc) pend.push_back(inInst);
      if (iss) begin
        expInst = pend.pop_front();
        sb.push_back(expInst);
      end
      expEn = iss;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic prevEn = 1'b0;
  always @(negedge Clock) begin
    logic [15:0] want;
    if (started) begin
      chk("issueEnable", 32'(issueEnable), 32'(expEn));
      if (issueEnable === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_issue", 32'(issueInst), 32'hFFFF_FFFF);
        end else begin
          want = sb.pop_front();
          chk("issue_order", 32'(issueInst), 32'(want));
        end
        chk("no_back_to_back", 32'(prevEn), 32'd0);
      end
      chk("issueInst", 32'(issueInst), 32'(expInst));
      chk("count", 32'(count), 32'(pend.size()));
      chk("empty", 32'(empty), 32'(pend.size() == 0));
      chk("full", 32'(full), 32'(pend.size() == DEPTH));
      chk("inReady", 32'(inReady), 32'(!Reset && pend.size() < DEPTH));
      prevEn = issueEnable;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic push1(input logic [15:0] v);
    inValid = 1'b1;
    inInst  = v;
    tick();
    inValid = 1'b0;
  endtask

  initial begin
    bit got;
    // Reset with a push offered throughout.
    Reset = 1'b1; inValid = 1'b1; inInst = 16'hBEEF; disponivel = 1'b1;
    tick(3);
    Reset = 1'b0; inValid = 1'b0;
    tick(2);

    // Three back-to-back pushes with the station available.
    disponivel = 1'b1;
    push1(16'h0401); push1(16'h0C80); push1(16'h1105);
    tick(8);

    // Fill with the station busy; the ninth push is refused while full.
    disponivel = 1'b0;
    for (int i = 0; i < 9; i++) push1(16'h3000 + 16'(i));
    inValid = 1'b1; inInst = 16'h3008;
    tick(2);
    disponivel = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge Clock);
      got = inReady;
      tick();
    end
    inValid = 1'b0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL ninth_push_accept: inReady never rose, expected 1");
    end
    tick(25);

    // Wrap-around with occupancy around 3.
    disponivel = 1'b0;
    for (int i = 0; i < 3; i++) push1(16'h4000 + 16'(i));
    disponivel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push1(16'h4100 + 16'(i));
      tick();
    end
    tick(12);

    // Flush with 5 queued and a push offered in the same cycle.
    disponivel = 1'b0;
    for (int i = 0; i < 5; i++) push1(16'h5000 + 16'(i));
    flush = 1'b1; inValid = 1'b1; inInst = 16'hDEAD;
    tick();
    flush = 1'b0; inValid = 1'b0; disponivel = 1'b1;
    tick(4);

    // Single push into an empty queue (bypass or one-edge latency).
    push1(16'h2A81);
    tick(4);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      inValid    = ($urandom_range(0, 99) < 60);
      inInst     = 16'($urandom);
      disponivel = ($urandom_range(0, 99) < 55);
      flush      = ($urandom_range(0, 99) < 3);
      Reset      = ($urandom_range(0, 199) < 1);
      tick();
    end
    Reset = 1'b0; flush = 1'b0; inValid = 1'b0; disponivel = 1'b1;
    tick(30);

    @(negedge Clock);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
